seg8_4: RTL and testbench

SEG8_4 -- requirements
Module: seg8_4

---
 rtl/seg8_4.sv | 114 +++++++++++
 tb/tb_seg8_4.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/seg8_4.sv
// rtl/seg8_4.sv - four-digit multiplexed seven-segment hex driver, registered sel/seg outputs.
// Optional leading-zero blanking is enabled by defining SEG8_4_BLANK_EN.
module seg8_4 #(
  parameter int unsigned SCAN_DIV = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] number,
  input  logic [3:0]  dot,
  output logic [3:0]  sel,
  output logic [7:0]  seg
);

  localparam int unsigned CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);

  logic [1:0]    idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          run_q;
  logic [3:0]    sel_q, sel_d;
  logic [7:0]    seg_q, seg_d;
  logic [3:0]    nib;
  logic [6:0]    pat;
  logic          blank;

  // run_q holds the scan on digit0 for the first edge after reset
  always_comb begin
    idx_d = idx_q;
    cnt_d = cnt_q;
    if (!run_q) begin
      idx_d = 2'd0;
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      idx_d = idx_q + 2'd1;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_comb begin
    nib = 4'h0;
    case (idx_d)
      2'd0: nib = number[3:0];
      2'd1: nib = number[7:4];
      2'd2: nib = number[11:8];
      2'd3: nib = number[15:12];
      default: nib = 4'h0;
    endcase
  end

  always_comb begin
    pat = 7'h00;
    case (nib)
      4'h0: pat = 7'h3F;
      4'h1: pat = 7'h06;
      4'h2: pat = 7'h5B;
      4'h3: pat = 7'h4F;
      4'h4: pat = 7'h66;
      4'h5: pat = 7'h6D;
      4'h6: pat = 7'h7D;
      4'h7: pat = 7'h07;
      4'h8: pat = 7'h7F;
      4'h9: pat = 7'h6F;
      4'hA: pat = 7'h77;
      4'hB: pat = 7'h7C;
      4'hC: pat = 7'h39;
      4'hD: pat = 7'h5E;
      4'hE: pat = 7'h79;
      4'hF: pat = 7'h71;
      default: pat = 7'h00;
    endcase
  end

  always_comb begin
    blank = 1'b0;
`ifdef SEG8_4_BLANK_EN
    // a digit is blank only if it and every digit to its left are zero
    case (idx_d)
      2'd1: blank = (number[15:4] == 12'h000);
      2'd2: blank = (number[15:8] == 8'h00);
      2'd3: blank = (number[15:12] == 4'h0);
      default: blank = 1'b0;
    endcase
`else
    blank = 1'b0;
`endif
  end

  always_comb begin
    sel_d = ~(4'b0001 << idx_d);
    seg_d = {~dot[idx_d], blank ? 7'h7F : ~pat};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q <= 2'd0;
      cnt_q <= '0;
      run_q <= 1'b0;
      sel_q <= 4'hF;
      seg_q <= 8'hFF;
    end else begin
      idx_q <= idx_d;
      cnt_q <= cnt_d;
      run_q <= 1'b1;
      sel_q <= sel_d;
      seg_q <= seg_d;
    end
  end

  assign sel = sel_q;
  assign seg = seg_q;

endmodule

// File: tb/tb_seg8_4.sv
// tb/tb_seg8_4.sv - directed self-checking bench for seg8_4 (SCAN_DIV 1 and 3 instances).
module tb_seg8_4;

  logic        clk = 1'b0;
  logic        rst1, rst3;
  logic [15:0] number;
  logic [3:0]  dot;
  logic [3:0]  sel1, sel3;
  logic [7:0]  seg1, seg3;
  int          checks = 0;
  int          failures = 0;
  int          n1, n3;
  logic [7:0]  e1234 [4];

  always #5 clk = ~clk;

  seg8_4 #(.SCAN_DIV(1)) dut1 (
    .clk(clk), .rst(rst1), .number(number), .dot(dot), .sel(sel1), .seg(seg1)
  );
  seg8_4 #(.SCAN_DIV(3)) dut3 (
    .clk(clk), .rst(rst3), .number(number), .dot(dot), .sel(sel3), .seg(seg3)
  );

  function automatic logic [7:0] exp_seg(input logic [15:0] num, input logic [3:0] dt, input int d);
    logic [3:0] h;
    logic [6:0] p;
    logic       bl;
    h = 4'(num >> (4 * d));
    case (h)
      4'h0: p = 7'h3F; 4'h1: p = 7'h06; 4'h2: p = 7'h5B; 4'h3: p = 7'h4F;
      4'h4: p = 7'h66; 4'h5: p = 7'h6D; 4'h6: p = 7'h7D; 4'h7: p = 7'h07;
      4'h8: p = 7'h7F; 4'h9: p = 7'h6F; 4'hA: p = 7'h77; 4'hB: p = 7'h7C;
      4'hC: p = 7'h39; 4'hD: p = 7'h5E; 4'hE: p = 7'h79; default: p = 7'h71;
    endcase
    bl = 1'b0;
`ifdef SEG8_4_BLANK_EN
    if (d == 3) bl = (num[15:12] == 4'h0);
    else if (d == 2) bl = (num[15:8] == 8'h00);
    else if (d == 1) bl = (num[15:4] == 12'h000);
`endif
    return {~dt[d], bl ? 7'h7F : ~p};
  endfunction

  function automatic logic blank_on();
`ifdef SEG8_4_BLANK_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [3:0] s;
    int d;
    if (n1 < 0) begin
      chk("sel1_rst", {4'h0, sel1}, 8'h0F);
      chk("seg1_rst", seg1, 8'hFF);
    end else begin
      d = n1 % 4;
      s = ~(4'b0001 << d);
      chk("sel1", {4'h0, sel1}, {4'h0, s});
      chk("seg1", seg1, exp_seg(number, dot, d));
    end
    if (n3 < 0) begin
      chk("sel3_rst", {4'h0, sel3}, 8'h0F);
      chk("seg3_rst", seg3, 8'hFF);
    end else begin
      d = (n3 / 3) % 4;
      s = ~(4'b0001 << d);
      chk("sel3", {4'h0, sel3}, {4'h0, s});
      chk("seg3", seg3, exp_seg(number, dot, d));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    n1 = rst1 ? -1 : n1 + 1;
    n3 = rst3 ? -1 : n3 + 1;
    @(negedge clk);
    check_all();
  endtask

  initial begin
    logic found;
    e1234[0] = 8'h99; e1234[1] = 8'hB0; e1234[2] = 8'hA4; e1234[3] = 8'hF9;
    n1 = -1;
    n3 = -1;
    rst1 = 1'b1;
    rst3 = 1'b1;
    number = 16'hBEEF;
    dot = 4'hF;
    @(negedge clk);
    for (int i = 0; i < 3; i++) tick();

    number = 16'h1234;
    dot = 4'h0;
    rst1 = 1'b0;
    rst3 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("seq1234_seg", seg1, e1234[n1 % 4]);
    end

    number = 16'h0000;
    dot = 4'b0001;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (n1 % 4 == 0) chk("zero_d0", seg1, 8'h40);
      else chk("zero_dn", seg1, blank_on() ? 8'hFF : 8'hC0);
    end

    number = 16'h0012;
    dot = 4'h0;
    for (int i = 0; i < 4; i++) tick();

    number = 16'h0000;
    dot = 4'b1000;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (n1 % 4 == 3) chk("dp_d3", seg1, blank_on() ? 8'h7F : 8'h40);
    end

    number = 16'h1234;
    dot = 4'h0;
    found = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      tick();
      if (n1 % 4 == 1) found = 1'b1;
    end
    chk("wait_digit1", {7'h0, found}, 8'h01);
    number = 16'hABCD;
    tick();
    chk("midframe_d2", seg1, 8'h83);

    found = 1'b0;
    for (int i = 0; i < 16 && !found; i++) begin
      tick();
      if ((n3 / 3) % 4 == 2) found = 1'b1;
    end
    chk("wait_digit2", {7'h0, found}, 8'h01);
    rst3 = 1'b1;
    tick();
    chk("midrst_sel3", {4'h0, sel3}, 8'h0F);
    chk("midrst_seg3", seg3, 8'hFF);
    rst3 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("restart_sel3", {4'h0, sel3}, 8'h0E);
    end
    tick();
    chk("advance_sel3", {4'h0, sel3}, 8'h0D);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
